// File: rtl/bus_sequencer_pkg.sv
// Shared types for the bus sequencer: sequence word layout, decoded
// instruction types, controller states and the jump-target helper.
package bus_sequencer_pkg;

    localparam int JMP_VAL_W  = 8;
    localparam int DATA_W     = 16;
    localparam int MAX_ADDR_W = 16;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'd0,
        RUN_INSTR = 2'd1,
        CMD_END   = 2'd2,
        CMD_RSVD  = 2'd3
    } cmd_t;

    typedef enum logic [2:0] {
        INSTR_NOP        = 3'd0,
        INSTR_WRITE      = 3'd1,
        INSTR_READ       = 3'd2,
        INSTR_WAIT       = 3'd3,
        INSTR_UNCOND_JMP = 3'd4,
        INSTR_COMP_JMP   = 3'd5,
        INSTR_RSVD6      = 3'd6,
        INSTR_RSVD7      = 3'd7
    } instr_t;

    typedef logic [DATA_W-1:0] instr_data_t;

    typedef struct packed {
        cmd_t                 cmd_type;
        instr_t               instr;
        logic                 jmp_dir_up;
        logic [JMP_VAL_W-1:0] jmp_value;
        instr_data_t          data;
    } seq_word_t;

    function automatic int get_word_width();
        return $bits(seq_word_t);
    endfunction

    function automatic int get_data_width();
        return DATA_W;
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        DISPATCH,
        EXEC,
        DONE,
        ERR
    } ctrl_state_t;

    // Returns {overflow, addr}; "up" walks toward address 0.
    function automatic logic [MAX_ADDR_W:0] jump_target(
        input logic [MAX_ADDR_W-1:0] pc,
        input logic [MAX_ADDR_W-1:0] val,
        input logic                  up,
        input logic [MAX_ADDR_W-1:0] last
    );
        logic [MAX_ADDR_W:0] sum;
        logic                ovf;
        if (up) begin
            sum = {1'b0, pc} - {1'b0, val};
            ovf = sum[MAX_ADDR_W];
        end else begin
            sum = {1'b0, pc} + {1'b0, val};
            ovf = sum > {1'b0, last};
        end
        return {ovf, sum[MAX_ADDR_W-1:0]};
    endfunction

endpackage

// File: rtl/bus_seq_ctrl_decoder.sv
// Combinational decode of one sequence word into control flags
// and the instruction handed to the executor.
module bus_seq_ctrl_decoder
    import bus_sequencer_pkg::*;
(
    input  seq_word_t            word,
    output logic                 run,
    output logic                 jmp_en,
    output logic                 jmp_cond,
    output logic                 jmp_up,
    output logic [JMP_VAL_W-1:0] jmp_value,
    output instr_t               instr,
    output instr_data_t          data
);

    assign run       = word.cmd_type == RUN_INSTR;
    assign jmp_up    = word.jmp_dir_up;
    assign jmp_value = word.jmp_value;
    assign instr     = word.instr;
    assign data      = word.data;

    always_comb begin
        jmp_en   = 1'b0;
        jmp_cond = 1'b0;
        unique case (1'b1)
            (word.instr == INSTR_UNCOND_JMP): begin
                jmp_en = 1'b1;
            end
            (word.instr == INSTR_COMP_JMP): begin
                jmp_en   = 1'b1;
                jmp_cond = 1'b1;
            end
            default: begin
                jmp_en = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/bus_seq_ctrl.sv
// Program-flow controller: fetches sequence words, resolves jumps and
// hands instructions to the bus executor over valid/ready.
module bus_seq_ctrl
    import bus_sequencer_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int START_ADDR = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    input  logic                        abort_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    output logic [ADDR_W-1:0]           pc_o,
    output logic                        mem_rd_o,
    output logic [ADDR_W-1:0]           mem_addr_o,
    input  logic [get_word_width()-1:0] mem_data_i,
    output logic                        exec_valid_o,
    input  logic                        exec_ready_i,
    output instr_t                      exec_type_o,
    output instr_data_t                 exec_data_o,
    input  logic                        cmp_flag_i
);

    localparam logic [ADDR_W-1:0] START   = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] PC_LAST = '1;

    ctrl_state_t       state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              cmp_q, cmp_d;
    seq_word_t         word_q;

    logic                 run;
    logic                 jmp_en;
    logic                 jmp_cond;
    logic                 jmp_up;
    logic [JMP_VAL_W-1:0] jmp_raw;
    instr_t               d_instr;
    instr_data_t          d_data;

    bus_seq_ctrl_decoder u_dec (
        .word      (word_q),
        .run       (run),
        .jmp_en    (jmp_en),
        .jmp_cond  (jmp_cond),
        .jmp_up    (jmp_up),
        .jmp_value (jmp_raw),
        .instr     (d_instr),
        .data      (d_data)
    );

    logic [ADDR_W-1:0]            jmp_val;
    logic [MAX_ADDR_W:0]          jt;
    logic [MAX_ADDR_W-ADDR_W:0]   jt_hi;
    logic [ADDR_W-1:0]            jmp_addr;
    logic                         jmp_take;
    logic                         jmp_bad;
    logic                         pc_last;
    logic [ADDR_W-1:0]            pc_inc;
    logic                         exec_offer;
    logic                         exec_hs;

    assign jmp_val = ADDR_W'(jmp_raw);
    assign jt      = jump_target(MAX_ADDR_W'(pc_q), MAX_ADDR_W'(jmp_val),
                                 jmp_up, MAX_ADDR_W'(PC_LAST));
    // Any bit above the address range means borrow or carry.
    assign {jt_hi, jmp_addr} = jt;
    assign jmp_take = !jmp_cond || cmp_q;
    assign jmp_bad  = (|jt_hi) || (jmp_val == '0);
    assign pc_last  = pc_q == PC_LAST;
    assign pc_inc   = pc_q + ADDR_W'(1);

    assign exec_offer = (state_q == DISPATCH && run && !jmp_en)
                     || (state_q == EXEC);
    assign exec_hs    = exec_offer && exec_ready_i;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cmp_d   = cmp_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    pc_d    = START;
                    state_d = FETCH;
                end
            end
            FETCH:    state_d = WAIT;
            WAIT:     state_d = DISPATCH;
            DISPATCH: begin
                if (!run) begin
                    state_d = DONE;
                end else if (jmp_en && !jmp_take) begin
                    if (pc_last) begin
                        state_d = ERR;
                    end else begin
                        pc_d    = pc_inc;
                        state_d = FETCH;
                    end
                end else if (jmp_en) begin
                    if (jmp_bad) begin
                        state_d = ERR;
                    end else begin
                        pc_d    = jmp_addr;
                        state_d = FETCH;
                    end
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC:     state_d = EXEC;
            DONE:     state_d = IDLE;
            ERR:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        // A handshake can complete in DISPATCH already, skipping EXEC.
        if (exec_hs) begin
            cmp_d = cmp_flag_i;
            if (pc_last) begin
                state_d = ERR;
            end else begin
                pc_d    = pc_inc;
                state_d = FETCH;
            end
        end
        if (abort_i) begin
            state_d = IDLE;
            pc_d    = pc_q;
            cmp_d   = cmp_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pc_q    <= START;
            cmp_q   <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cmp_q   <= cmp_d;
            if (state_q == WAIT) begin
                word_q <= seq_word_t'(mem_data_i);
            end
        end
    end

    assign busy_o       = state_q != IDLE;
    assign done_o       = state_q == DONE;
    assign err_o        = state_q == ERR;
    assign pc_o         = pc_q;
    assign mem_rd_o     = state_q == FETCH;
    assign mem_addr_o   = pc_q;
    assign exec_valid_o = exec_offer;
    assign exec_type_o  = exec_offer ? d_instr : INSTR_NOP;
    assign exec_data_o  = exec_offer ? d_data : '0;

endmodule

// File: tb/tb_bus_seq_ctrl.sv
// Bench for bus_seq_ctrl: directed flow cases plus random programs
// compared against an instruction-level program model.
module tb_bus_seq_ctrl;
    import bus_sequencer_pkg::*;

    localparam int AW = 8;
    localparam int WW = get_word_width();

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic          abort_i;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [AW-1:0] pc_o;
    logic          mem_rd_o;
    logic [AW-1:0] mem_addr_o;
    logic [WW-1:0] mem_data_i;
    logic          exec_valid_o;
    logic          exec_ready_i;
    instr_t        exec_type_o;
    instr_data_t   exec_data_o;
    logic          cmp_flag_i;

    bus_seq_ctrl #(.ADDR_W(AW), .START_ADDR(0)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .pc_o         (pc_o),
        .mem_rd_o     (mem_rd_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_i   (mem_data_i),
        .exec_valid_o (exec_valid_o),
        .exec_ready_i (exec_ready_i),
        .exec_type_o  (exec_type_o),
        .exec_data_o  (exec_data_o),
        .cmp_flag_i   (cmp_flag_i)
    );

    always #5 clk = ~clk;

    seq_word_t   mem [256];
    logic        cmp_seq [128];
    int          hs_cnt = 0;
    int          hs_base = 0;
    int          valid_cycles = 0;
    logic [6:0]  hs_idx;
    instr_t      got_t [$];
    instr_data_t got_d [$];
    instr_t      exp_t [$];
    instr_data_t exp_d [$];

    int vectors = 0;
    int miscompares = 0;

    bit m_cmp;
    bit m_cmp_next;
    int m_words;
    bit m_err;
    bit m_ok;
    int m_pc;

    assign hs_idx     = 7'(hs_cnt - hs_base);
    assign cmp_flag_i = cmp_seq[hs_idx];

    always @(posedge clk) begin
        if (mem_rd_o) mem_data_i <= mem[mem_addr_o];
    end

    always @(posedge clk) begin
        if (rst_ni) begin
            if (exec_valid_o) valid_cycles <= valid_cycles + 1;
            if (exec_valid_o && exec_ready_i && !abort_i) begin
                got_t.push_back(exec_type_o);
                got_d.push_back(exec_data_o);
                hs_cnt <= hs_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic seq_word_t wr(input instr_t t, input instr_data_t d);
        seq_word_t w;
        w          = '0;
        w.cmd_type = RUN_INSTR;
        w.instr    = t;
        w.data     = d;
        return w;
    endfunction

    function automatic seq_word_t wj(input instr_t t, input logic up,
                                     input logic [7:0] v);
        seq_word_t w;
        w            = '0;
        w.cmd_type   = RUN_INSTR;
        w.instr      = t;
        w.jmp_dir_up = up;
        w.jmp_value  = v;
        return w;
    endfunction

    function automatic seq_word_t wend();
        seq_word_t w;
        w          = '0;
        w.cmd_type = CMD_END;
        return w;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    // Walks the program word by word following the instruction rules.
    task automatic model_run();
        int        pc;
        int        tgt;
        int        k;
        bit        cmp;
        seq_word_t w;
        pc = 0;
        k = 0;
        cmp = m_cmp;
        m_words = 0;
        m_ok = 0;
        m_err = 0;
        m_pc = 0;
        exp_t.delete();
        exp_d.delete();
        for (int s = 0; s < 100; s++) begin
            w = mem[pc];
            m_words++;
            if (w.cmd_type != RUN_INSTR) begin
                m_pc = pc;
                m_ok = 1;
                break;
            end
            if (w.instr == INSTR_UNCOND_JMP || w.instr == INSTR_COMP_JMP) begin
                if (w.instr == INSTR_UNCOND_JMP || cmp) begin
                    tgt = w.jmp_dir_up ? pc - int'(w.jmp_value)
                                       : pc + int'(w.jmp_value);
                    if (w.jmp_value == 0 || tgt < 0 || tgt > 255) begin
                        m_err = 1;
                        m_ok = 1;
                        break;
                    end
                    pc = tgt;
                end else if (pc == 255) begin
                    m_err = 1;
                    m_ok = 1;
                    break;
                end else begin
                    pc++;
                end
            end else begin
                exp_t.push_back(w.instr);
                exp_d.push_back(w.data);
                cmp = cmp_seq[k];
                k++;
                if (pc == 255) begin
                    m_err = 1;
                    m_ok = 1;
                    break;
                end
                pc++;
            end
        end
        m_cmp_next = cmp;
    endtask

    task automatic run_prog(input bit rdy_rand, input bit chk_cycles);
        int cyc;
        int vbase;
        int n;
        model_run();
        chk("model_terminates", 32'(m_ok), 32'd1);
        got_t.delete();
        got_d.delete();
        hs_base = hs_cnt;
        vbase = valid_cycles;
        @(negedge clk);
        start_i = 1'b1;
        exec_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        exec_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        chk("start_latency_rd", 32'(mem_rd_o), 32'd1);
        chk("start_addr", 32'(mem_addr_o), 32'd0);
        cyc = 1;
        while (!(done_o || err_o) && cyc < 3000) begin
            @(negedge clk);
            exec_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc++;
        end
        chk("run_timeout", 32'(cyc < 3000), 32'd1);
        chk("outcome_err", 32'(err_o), 32'(m_err));
        chk("outcome_done", 32'(done_o), 32'(!m_err));
        if (!m_err) chk("end_pc", 32'(pc_o), 32'(m_pc));
        if (chk_cycles) chk("end_cycle", 32'(cyc), 32'(3 * m_words + 1));
        chk("exec_count", 32'(got_t.size()), 32'(exp_t.size()));
        if (exp_t.size() == 0) chk("no_valid", 32'(valid_cycles - vbase), 32'd0);
        n = got_t.size() < exp_t.size() ? got_t.size() : exp_t.size();
        for (int i = 0; i < n; i++) begin
            chk("exec_type", 32'(got_t[i]), 32'(exp_t[i]));
            chk("exec_data", 32'(got_d[i]), 32'(exp_d[i]));
        end
        m_cmp = m_cmp_next;
        @(negedge clk);
        exec_ready_i = 1'b0;
        chk("back_to_idle", 32'(busy_o), 32'd0);
    endtask

    task automatic gen_prog();
        int r;
        clear_mem();
        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)
                mem[i] = wr(instr_t'(3'($urandom_range(0, 3))),
                            16'($urandom));
            else if (r == 6)
                mem[i] = wj(INSTR_UNCOND_JMP, 1'($urandom_range(0, 1)),
                            8'($urandom_range(0, 6)));
            else if (r == 7)
                mem[i] = wj(INSTR_COMP_JMP, 1'($urandom_range(0, 1)),
                            8'($urandom_range(0, 6)));
            else
                mem[i] = wend();
        end
        for (int i = 0; i < 128; i++) cmp_seq[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic check_idle_outputs(input string tag, input logic [AW-1:0] pc);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_err"}, 32'(err_o), 32'd0);
        chk({tag, "_pc"}, 32'(pc_o), 32'(pc));
        chk({tag, "_rd"}, 32'(mem_rd_o), 32'd0);
        chk({tag, "_valid"}, 32'(exec_valid_o), 32'd0);
        chk({tag, "_type"}, 32'(exec_type_o), 32'd0);
        chk({tag, "_data"}, 32'(exec_data_o), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        exec_ready_i = 1'b0;
        mem_data_i = '0;
        m_cmp = 1'b0;
        clear_mem();
        for (int i = 0; i < 128; i++) cmp_seq[i] = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset", '0);
        rst_ni = 1'b1;

        // Two executes then end of sequence.
        clear_mem();
        mem[0] = wr(INSTR_WRITE, 16'hA5A5);
        mem[1] = wr(INSTR_READ, 16'h5A5A);
        mem[2] = wend();
        cmp_seq[0] = 1'b1;
        cmp_seq[1] = 1'b1;
        run_prog(0, 1);

        // Unconditional jumps in both directions.
        clear_mem();
        mem[0] = wj(INSTR_UNCOND_JMP, 0, 8'd3);
        mem[3] = wj(INSTR_UNCOND_JMP, 1, 8'd2);
        mem[1] = wend();
        run_prog(0, 1);
        mem[3] = wj(INSTR_UNCOND_JMP, 0, 8'd4);
        mem[7] = wend();
        run_prog(0, 1);

        // Compare jump: taken once, then falls through.
        clear_mem();
        mem[0] = wj(INSTR_UNCOND_JMP, 0, 8'd2);
        mem[2] = wr(INSTR_WAIT, 16'h1234);
        mem[3] = wj(INSTR_COMP_JMP, 1, 8'd1);
        mem[4] = wend();
        cmp_seq[0] = 1'b1;
        cmp_seq[1] = 1'b0;
        run_prog(0, 1);
        cmp_seq[0] = 1'b0;
        run_prog(0, 1);

        // Range errors: borrow, zero self-loop, carry, increment past end.
        clear_mem();
        mem[0] = wj(INSTR_UNCOND_JMP, 0, 8'd3);
        mem[3] = wj(INSTR_UNCOND_JMP, 1, 8'd5);
        run_prog(0, 1);
        mem[0] = wj(INSTR_UNCOND_JMP, 0, 8'd0);
        run_prog(0, 1);
        clear_mem();
        mem[0] = wj(INSTR_UNCOND_JMP, 0, 8'd250);
        mem[250] = wj(INSTR_UNCOND_JMP, 0, 8'd10);
        run_prog(0, 1);
        clear_mem();
        mem[0] = wj(INSTR_UNCOND_JMP, 0, 8'd254);
        mem[254] = wr(INSTR_WRITE, 16'h00FE);
        mem[255] = wr(INSTR_READ, 16'h00FF);
        run_prog(1, 0);

        for (int p = 0; p < 24; p++) begin
            for (int t = 0; t < 50; t++) begin
                gen_prog();
                model_run();
                if (m_ok) break;
            end
            run_prog(p[0], !p[0]);
        end

        // Stall, ignored start, then abort racing a handshake.
        clear_mem();
        mem[0] = wr(INSTR_WRITE, 16'h0F0F);
        mem[1] = wend();
        cmp_seq[0] = 1'b1;
        run_prog(0, 1);
        hs_base = hs_cnt;
        cmp_seq[0] = 1'b0;
        got_t.delete();
        exec_ready_i = 1'b0;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", 32'(exec_valid_o), 32'd1);
            chk("stall_type", 32'(exec_type_o), 32'(INSTR_WRITE));
            chk("stall_data", 32'(exec_data_o), 32'h0F0F);
            start_i = (c == 1);
            @(negedge clk);
            start_i = 1'b0;
            if (c == 1) chk("start_ignored", 32'(mem_rd_o), 32'd0);
        end
        abort_i = 1'b1;
        exec_ready_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        exec_ready_i = 1'b0;
        chk("abort_valid", 32'(exec_valid_o), 32'd0);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_no_hs", 32'(got_t.size()), 32'd0);
        // Compare flag must still hold the pre-abort value.
        clear_mem();
        mem[0] = wj(INSTR_COMP_JMP, 0, 8'd2);
        mem[1] = wend();
        mem[2] = wend();
        run_prog(0, 1);

        @(negedge clk);
        start_i = 1'b1;
        abort_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        abort_i = 1'b0;
        chk("start_abort_busy", 32'(busy_o), 32'd0);
        chk("start_abort_rd", 32'(mem_rd_o), 32'd0);

        // Asynchronous reset while an instruction waits in EXEC.
        clear_mem();
        mem[0] = wj(INSTR_UNCOND_JMP, 0, 8'd3);
        mem[3] = wr(INSTR_READ, 16'hBEEF);
        exec_ready_i = 1'b0;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_reset_valid", 32'(exec_valid_o), 32'd1);
        chk("pre_reset_pc", 32'(pc_o), 32'd3);
        rst_ni = 1'b0;
        #1;
        check_idle_outputs("async_reset", '0);
        @(negedge clk);
        rst_ni = 1'b1;
        m_cmp = 1'b0;
        clear_mem();
        mem[0] = wr(INSTR_WRITE, 16'h1111);
        mem[1] = wr(INSTR_READ, 16'h2222);
        mem[2] = wend();
        run_prog(0, 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
